// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg -- shared constants and helpers for the programmable clock
// generator (clk_gen_prog / clk_gen_chan).
//   DIV_MIN     : smallest divisor that actually takes effect
//   CNT_W_DEF   : default divisor / counter width
//   DIV_RST_DEF : default divisor loaded into every channel at reset
//   CH_IDX_W    : width of the channel-select field of a divisor write
package clk_gen_pkg;

  localparam int unsigned DIV_MIN     = 2;
  localparam int          CNT_W_DEF   = 16;
  localparam int          DIV_RST_DEF = 16;
  localparam int          CHX_DUMMY   = 0;
  localparam int          CH_IDX_W    = 3;

  // Divisors below DIV_MIN are kept as written but behave as DIV_MIN.
  function automatic int unsigned eff_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// clk_gen_chan -- one divided-clock channel.
// Holds an active divisor, a shadow divisor and a period counter. A new
// divisor written mid-period waits in the shadow register (o_pend high) and
// is applied on the wrap edge, so no phase is ever cut short or stretched.
// Ports:
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset (already release-synchronised)
//   i_en      : channel enable, level-sensitive
//   i_wr      : divisor write strobe for this channel
//   i_val     : divisor value written (period in clock cycles)
//   o_clk_out : registered divided clock
//   o_tick    : one-cycle pulse in the first cycle of every period
//   o_pend    : a written divisor is waiting for the period boundary
module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_pend
);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_run;
  logic             r_clk_out;
  logic             r_tick;

  logic [CNT_W-1:0] w_deff_cur;
  logic [CNT_W-1:0] w_deff_nxt;
  logic             w_last;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_shd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;

  assign w_deff_cur = CNT_W'(eff_div(32'(r_div)));

  // r_run marks that the previous cycle was counting; the first enabled
  // cycle therefore always starts at cnt=0 rather than continuing.
  assign w_last = r_run && (r_cnt >= (w_deff_cur - CNT_W'(1)));

  always_comb begin
    w_div_nxt  = r_div;
    w_shd_nxt  = r_shd;
    w_pend_nxt = r_pend;
    w_cnt_nxt  = '0;
    if (!i_en || w_last) begin
      // Period boundary (or idle): a write in this very cycle bypasses the
      // shadow, otherwise a pending shadow value becomes active.
      if (i_wr) begin
        w_div_nxt = i_val;
        w_shd_nxt = i_val;
      end else if (r_pend) begin
        w_div_nxt = r_shd;
      end
      w_pend_nxt = 1'b0;
    end else begin
      if (i_wr) begin
        w_shd_nxt  = i_val;
        w_pend_nxt = 1'b1;
      end
      w_cnt_nxt = r_run ? (r_cnt + CNT_W'(1)) : '0;
    end
  end

  // Outputs are decoded from the next-state counter so that the registered
  // clk_out/tick line up with the counter value of the same cycle.
  assign w_deff_nxt = CNT_W'(eff_div(32'(w_div_nxt)));
  assign w_clk_nxt  = i_en && (w_cnt_nxt >= (w_deff_nxt >> 1));
  assign w_tick_nxt = i_en && (w_cnt_nxt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= CNT_W'(DIV_RST);
      r_shd     <= CNT_W'(DIV_RST);
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_run     <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_shd     <= w_shd_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_run     <= i_en;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pend    = r_pend;

endmodule

// File: rtl/clk_gen_prog.sv
// clk_gen_prog -- programmable multi-channel clock divider.
// N_CH independent channels, each producing a registered divided clock, a
// period-start tick and a pending-divisor flag. Divisors are written one
// channel at a time through div_wr/div_ch/div_val; writes addressed to a
// channel index >= N_CH are ignored.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset, release synchronised internally
//   en      : per-channel enable
//   div_wr  : one-cycle divisor write strobe
//   div_ch  : target channel of the write
//   div_val : divisor value (period in clk cycles; 0 and 1 act as 2)
//   clk_out : per-channel divided clock
//   tick    : per-channel first-cycle-of-period pulse
//   pend    : per-channel written divisor awaiting its period boundary
module clk_gen_prog
  import clk_gen_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     en,
  input  logic                div_wr,
  input  logic [CH_IDX_W-1:0] div_ch,
  input  logic [CNT_W-1:0]    div_val,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     pend
);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [N_CH-1:0] w_wr;

  // Assertion reaches the channels asynchronously through the flop reset;
  // release is delayed by two clk edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_wr[g] = div_wr && (div_ch == CH_IDX_W'(g));

    clk_gen_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .i_clk     (clk),
      .i_rst_n   (w_rst_n),
      .i_en      (en[g]),
      .i_wr      (w_wr[g]),
      .i_val     (div_val),
      .o_clk_out (clk_out[g]),
      .o_tick    (tick[g]),
      .o_pend    (pend[g])
    );
  end

endmodule
